alarm_clock: RTL and testbench

24-hour BCD digital clock with two HH:MM alarms and six 7-segment digit decoders. It advances HH:MM:SS by one second per `clk` rising edge (`clk` is the 1 Hz timebase) and raises a latched `alarm_out` when the time reaches either programmed alarm. It also drives one 7-segment pattern per displayed digit. It sits between the 1 Hz tick source and the display/buzzer drivers.

---
 rtl/alarm_clock.sv | 145 ++++++++++++++
 tb/tb_alarm_clock.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour BCD HH:MM:SS clock advanced once per clk edge (1 Hz),
// with two HH:MM alarms driving a latched alarm_out and six 7-segment decoders.
module alarm_clock (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] alarm1,
   input  logic [15:0] alarm2,
   input  logic        stop_alarm,
   input  logic        alarm_en,
   output logic [3:0]  hour1,
   output logic [3:0]  hour0,
   output logic [3:0]  min1,
   output logic [3:0]  min0,
   output logic [3:0]  sec1,
   output logic [3:0]  sec0,
   output logic        alarm_out,
   output logic [6:0]  d1,
   output logic [6:0]  d2,
   output logic [6:0]  d3,
   output logic [6:0]  d4,
   output logic [6:0]  d5,
   output logic [6:0]  d6
);

   logic [3:0] nxt_h1, nxt_h0, nxt_m1, nxt_m0, nxt_s1, nxt_s0;
   logic       hit1, hit2;

   // An alarm word is usable only if every nibble is BCD and HH:MM is a real time.
   function automatic logic alarm_valid(input logic [15:0] a);
      logic ok;
      ok = (a[15:12] <= 4'd2) && (a[11:8] <= 4'd9) &&
           (a[7:4]   <= 4'd5) && (a[3:0]  <= 4'd9);
      if (a[15:12] == 4'd2 && a[11:8] > 4'd3)
         ok = 1'b0;
      return ok;
   endfunction

   // Match against the time about to be loaded, so alarm_out rises with HH:MM:00.
   function automatic logic alarm_hit(input logic [15:0] a,
                                      input logic [15:0] hhmm,
                                      input logic [3:0]  s1,
                                      input logic [3:0]  s0);
      return alarm_valid(a) && (a == hhmm) && (s1 == 4'd0) && (s0 == 4'd0);
   endfunction

   // Active-high segments, bit6..bit0 = a..g; non-decimal values blank the digit.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // BCD carry chain producing the time one second ahead, wrapping 23:59:59 to 00:00:00.
   always_comb begin
      nxt_h1 = hour1;
      nxt_h0 = hour0;
      nxt_m1 = min1;
      nxt_m0 = min0;
      nxt_s1 = sec1;
      nxt_s0 = sec0;
      if (sec0 != 4'd9) begin
         nxt_s0 = sec0 + 4'd1;
      end else begin
         nxt_s0 = 4'd0;
         if (sec1 != 4'd5) begin
            nxt_s1 = sec1 + 4'd1;
         end else begin
            nxt_s1 = 4'd0;
            if (min0 != 4'd9) begin
               nxt_m0 = min0 + 4'd1;
            end else begin
               nxt_m0 = 4'd0;
               if (min1 != 4'd5) begin
                  nxt_m1 = min1 + 4'd1;
               end else begin
                  nxt_m1 = 4'd0;
                  if (hour1 == 4'd2 && hour0 == 4'd3) begin
                     nxt_h1 = 4'd0;
                     nxt_h0 = 4'd0;
                  end else if (hour0 == 4'd9) begin
                     nxt_h0 = 4'd0;
                     nxt_h1 = hour1 + 4'd1;
                  end else begin
                     nxt_h0 = hour0 + 4'd1;
                  end
               end
            end
         end
      end
   end

   assign hit1 = alarm_hit(alarm1, {nxt_h1, nxt_h0, nxt_m1, nxt_m0}, nxt_s1, nxt_s0);
   assign hit2 = alarm_hit(alarm2, {nxt_h1, nxt_h0, nxt_m1, nxt_m0}, nxt_s1, nxt_s0);

   // Time-of-day registers: cleared asynchronously, advanced one second per edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hour1 <= 4'd0;
         hour0 <= 4'd0;
         min1  <= 4'd0;
         min0  <= 4'd0;
         sec1  <= 4'd0;
         sec0  <= 4'd0;
      end else begin
         hour1 <= nxt_h1;
         hour0 <= nxt_h0;
         min1  <= nxt_m1;
         min0  <= nxt_m0;
         sec1  <= nxt_s1;
         sec0  <= nxt_s0;
      end
   end

   // Latched alarm: stop and disable override a match; otherwise hold until cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         alarm_out <= 1'b0;
      else if (stop_alarm)
         alarm_out <= 1'b0;
      else if (!alarm_en)
         alarm_out <= 1'b0;
      else if (hit1 || hit2)
         alarm_out <= 1'b1;
   end

   assign d1 = seg7(hour1);
   assign d2 = seg7(hour0);
   assign d3 = seg7(min1);
   assign d4 = seg7(min0);
   assign d5 = seg7(sec1);
   assign d6 = seg7(sec0);

endmodule

// File: tb/tb_alarm_clock.sv
// tb_alarm_clock: scoreboard bench. A seconds-count model predicts time and
// alarm state each edge; predictions are queued and popped against the DUT.
module tb_alarm_clock;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] alarm1 = 16'h0000;
   logic [15:0] alarm2 = 16'h0000;
   logic        stop_alarm = 1'b0;
   logic        alarm_en = 1'b0;
   logic [3:0]  hour1, hour0, min1, min0, sec1, sec0;
   logic        alarm_out;
   logic [6:0]  d1, d2, d3, d4, d5, d6;

   typedef struct packed {
      logic [23:0] bcd;
      logic        alm;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   m_t = 0;
   logic m_alarm = 1'b0;

   logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011};

   alarm_clock dut (
      .clk(clk), .reset(reset), .alarm1(alarm1), .alarm2(alarm2),
      .stop_alarm(stop_alarm), .alarm_en(alarm_en),
      .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0),
      .sec1(sec1), .sec0(sec0), .alarm_out(alarm_out),
      .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6)
   );

   always #5 clk = ~clk;

   // Seconds-of-day at which an alarm word fires, or -1 if it can never fire.
   function automatic int alarm_secs(input logic [15:0] a);
      int hh, mm;
      if (a[15:12] > 9 || a[11:8] > 9 || a[7:4] > 9 || a[3:0] > 9) return -1;
      hh = a[15:12] * 10 + a[11:8];
      mm = a[7:4] * 10 + a[3:0];
      if (hh > 23 || mm > 59) return -1;
      return hh * 3600 + mm * 60;
   endfunction

   function automatic logic [23:0] to_bcd(input int t);
      int hh, mm, ss;
      hh = t / 3600;
      mm = (t / 60) % 60;
      ss = t % 60;
      return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [41:0] segs_of(input logic [23:0] b);
      return {seg_tab[b[23:20]], seg_tab[b[19:16]], seg_tab[b[15:12]],
              seg_tab[b[11:8]], seg_tab[b[7:4]], seg_tab[b[3:0]]};
   endfunction

   // Advance n edges, stepping the model with the inputs seen at each edge;
   // optionally queue the prediction for the state after the last edge.
   task automatic run(input int n, input bit rec);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!reset) begin
            m_t = 0;
            m_alarm = 1'b0;
         end else begin
            m_t = (m_t + 1) % 86400;
            if (stop_alarm) m_alarm = 1'b0;
            else if (!alarm_en) m_alarm = 1'b0;
            else if (m_t == alarm_secs(alarm1) || m_t == alarm_secs(alarm2)) m_alarm = 1'b1;
         end
      end
      #1;
      if (rec) q.push_back('{to_bcd(m_t), m_alarm});
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_t = 0;
      m_alarm = 1'b0;
      run(1, 1'b0);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      int  n [4]    = '{0, 3, 1, 61};
      bit  rstv [4] = '{0, 0, 1, 1};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         reset = rstv[i];
         if (n[i] == 0) begin
            #1;
            q.push_back('{24'h0, 1'b0});
         end else begin
            run(n[i], 1'b1);
         end
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL reset[%0d]: no expected entry", i);
         end else begin
            e = q.pop_front();
            checks++;
            if ({hour1, hour0, min1, min0, sec1, sec0} !== e.bcd) begin
               failures++;
               $display("FAIL reset[%0d] time: got %h want %h", i, {hour1, hour0, min1, min0, sec1, sec0}, e.bcd);
            end
            checks++;
            if (alarm_out !== e.alm) begin
               failures++;
               $display("FAIL reset[%0d] alarm: got %b want %b", i, alarm_out, e.alm);
            end
            checks++;
            if ({d1, d2, d3, d4, d5, d6} !== segs_of(e.bcd)) begin
               failures++;
               $display("FAIL reset[%0d] segs: got %h want %h", i, {d1, d2, d3, d4, d5, d6}, segs_of(e.bcd));
            end
         end
         if (i == 0) begin
            checks++;
            if ({d1, d2, d3, d4, d5, d6} !== {6{7'b1111110}}) begin
               failures++;
               $display("FAIL reset_zero_segs: got %h want %h", {d1, d2, d3, d4, d5, d6}, {6{7'b1111110}});
            end
         end
         if (i == 2) begin
            checks++;
            if (d6 !== 7'b0110000) begin
               failures++;
               $display("FAIL d6_one: got %b want 0110000", d6);
            end
         end
      end
   endtask

   task automatic test_wraps();
      int tgt [8] = '{3599, 3600, 35999, 36000, 71999, 72000, 86399, 86400};
      int done;
      exp_t e;
      alarm1 = 16'h2460;
      alarm2 = 16'h2400;
      alarm_en = 1'b1;
      stop_alarm = 1'b0;
      do_reset();
      done = 0;
      for (int i = 0; i < 8; i++) begin
         run(tgt[i] - done, 1'b1);
         done = tgt[i];
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wrap[%0d]: no expected entry", i);
         end else begin
            e = q.pop_front();
            checks++;
            if ({hour1, hour0, min1, min0, sec1, sec0} !== e.bcd) begin
               failures++;
               $display("FAIL wrap[%0d] time: got %h want %h", i, {hour1, hour0, min1, min0, sec1, sec0}, e.bcd);
            end
            checks++;
            if (alarm_out !== e.alm) begin
               failures++;
               $display("FAIL wrap[%0d] invalid_alarm: got %b want %b", i, alarm_out, e.alm);
            end
            checks++;
            if ({d1, d2, d3, d4, d5, d6} !== segs_of(e.bcd)) begin
               failures++;
               $display("FAIL wrap[%0d] segs: got %h want %h", i, {d1, d2, d3, d4, d5, d6}, segs_of(e.bcd));
            end
         end
      end
   endtask

   task automatic test_alarm();
      int n [8]    = '{59, 1, 15, 1, 1, 162, 1, 1};
      bit stp [8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
      bit en [8]   = '{1, 1, 1, 1, 1, 1, 1, 0};
      exp_t e;
      alarm1 = 16'h0001;
      alarm2 = 16'h0004;
      alarm_en = 1'b1;
      stop_alarm = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         stop_alarm = stp[i];
         alarm_en = en[i];
         run(n[i], 1'b1);
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL alarm[%0d]: no expected entry", i);
         end else begin
            e = q.pop_front();
            checks++;
            if ({hour1, hour0, min1, min0, sec1, sec0} !== e.bcd) begin
               failures++;
               $display("FAIL alarm[%0d] time: got %h want %h", i, {hour1, hour0, min1, min0, sec1, sec0}, e.bcd);
            end
            checks++;
            if (alarm_out !== e.alm) begin
               failures++;
               $display("FAIL alarm[%0d] alarm_out: got %b want %b", i, alarm_out, e.alm);
            end
         end
      end
      stop_alarm = 1'b0;
   endtask

   task automatic test_alarm_disabled();
      exp_t e;
      alarm1 = 16'h0001;
      alarm2 = 16'h0004;
      alarm_en = 1'b0;
      stop_alarm = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run(60, 1'b1);
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL disabled[%0d]: no expected entry", i);
         end else begin
            e = q.pop_front();
            checks++;
            if (alarm_out !== e.alm) begin
               failures++;
               $display("FAIL disabled[%0d] alarm_out: got %b want %b", i, alarm_out, e.alm);
            end
         end
      end
   endtask

   task automatic test_stop_held();
      int n [3]   = '{30, 30, 1};
      bit stp [3] = '{1, 1, 0};
      exp_t e;
      alarm1 = 16'h0001;
      alarm2 = 16'h0004;
      alarm_en = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         stop_alarm = stp[i];
         run(n[i], 1'b1);
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL stop_held[%0d]: no expected entry", i);
         end else begin
            e = q.pop_front();
            checks++;
            if (alarm_out !== e.alm) begin
               failures++;
               $display("FAIL stop_held[%0d] alarm_out: got %b want %b", i, alarm_out, e.alm);
            end
         end
      end
   endtask

   task automatic test_alarm_change();
      int          n [2] = '{119, 1};
      logic [15:0] a [2] = '{16'h0003, 16'h0002};
      exp_t e;
      alarm2 = 16'h0004;
      alarm_en = 1'b1;
      stop_alarm = 1'b0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         alarm1 = a[i];
         run(n[i], 1'b1);
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL change[%0d]: no expected entry", i);
         end else begin
            e = q.pop_front();
            checks++;
            if ({hour1, hour0, min1, min0, sec1, sec0} !== e.bcd) begin
               failures++;
               $display("FAIL change[%0d] time: got %h want %h", i, {hour1, hour0, min1, min0, sec1, sec0}, e.bcd);
            end
            checks++;
            if (alarm_out !== e.alm) begin
               failures++;
               $display("FAIL change[%0d] alarm_out: got %b want %b", i, alarm_out, e.alm);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      alarm1 = 16'h0001;
      alarm2 = 16'h0004;
      alarm_en = 1'b1;
      stop_alarm = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: run(90, 1'b1);
            1: begin
               #2;
               reset = 1'b0;
               #1;
               m_t = 0;
               m_alarm = 1'b0;
               q.push_back('{to_bcd(m_t), m_alarm});
            end
            2: run(1, 1'b1);
            default: begin
               reset = 1'b1;
               run(1, 1'b1);
            end
         endcase
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL async[%0d]: no expected entry", i);
         end else begin
            e = q.pop_front();
            checks++;
            if ({hour1, hour0, min1, min0, sec1, sec0} !== e.bcd) begin
               failures++;
               $display("FAIL async[%0d] time: got %h want %h", i, {hour1, hour0, min1, min0, sec1, sec0}, e.bcd);
            end
            checks++;
            if (alarm_out !== e.alm) begin
               failures++;
               $display("FAIL async[%0d] alarm_out: got %b want %b", i, alarm_out, e.alm);
            end
         end
         if (i == 0) begin
            checks++;
            if (alarm_out !== 1'b1) begin
               failures++;
               $display("FAIL async_pre_alarm: got %b want 1", alarm_out);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alarm();
      test_alarm_disabled();
      test_stop_held();
      test_alarm_change();
      test_async_reset();
      test_wraps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
